// File: rtl/adc_pkg.sv
// Shared constants, channel type and responder state encoding for the serial ADC
// responder and the acquisition master that polls it.
package adc_pkg;

  localparam int ADC_DATA_W      = 12;
  localparam int ADC_FRAME_BITS  = 16;
  localparam int ADC_NUM_CH      = 8;
  localparam int ADC_SYNC_STAGES = 2;

  typedef logic [2:0] adc_chan_t;

  typedef enum logic {
    ADC_IDLE  = 1'b0,
    ADC_SHIFT = 1'b1
  } adc_state_e;

  // Rising edges 2..4 of a frame carry the channel address, MSB first.
  function automatic logic in_addr_window(input int bit_idx);
    return (bit_idx >= 2) && (bit_idx <= 4);
  endfunction

endpackage

// File: rtl/adc_responder_if.sv
// Serial ADC pin bundle: the master drives select, clock and address, the ADC returns data.
interface adc_if;
  logic CS_N;
  logic ADC_SCLK;
  logic ADC_SADDR;
  logic ADC_SDAT;

  modport master (
    output CS_N,
    output ADC_SCLK,
    output ADC_SADDR,
    input  ADC_SDAT
  );

  modport slave (
    input  CS_N,
    input  ADC_SCLK,
    input  ADC_SADDR,
    output ADC_SDAT
  );
endinterface

// File: rtl/adc_responder_sync_edge.sv
// N-stage synchronizer with one-clk rise/fall pulses derived from the synchronized level.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= STAGES'({sync_q, d_i});
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o =  q_o & ~prev_q;
  assign fall_o = ~q_o &  prev_q;

endmodule

// File: rtl/adc_responder.sv
// Slave-side model of the 8-channel 12-bit serial ADC: captures the channel address and
// shifts out the value of the channel addressed in the previous frame.
module adc_responder
  import adc_pkg::*;
#(
  parameter int DATA_W      = ADC_DATA_W,
  parameter int FRAME_BITS  = ADC_FRAME_BITS,
  parameter int NUM_CH      = ADC_NUM_CH,
  parameter int SYNC_STAGES = ADC_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              reset,
  adc_if.slave              bus,
  input  logic              wr_en,
  input  adc_chan_t         wr_chan,
  input  logic [DATA_W-1:0] wr_data,
  output logic              frame_done,
  output adc_chan_t         last_chan,
  output logic              busy
);

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  // Bit order {SADDR, SCLK, CS_N}: select and clock idle high, address idles low.
  localparam logic [2:0] SYNC_RST = 3'b011;

  logic [2:0] pin_raw, sync_lvl, sync_rise, sync_fall;

  assign pin_raw = {bus.ADC_SADDR, bus.ADC_SCLK, bus.CS_N};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    sync_edge #(
      .STAGES (SYNC_STAGES),
      .RST_VAL(SYNC_RST[gi])
    ) u_sync (
      .clk   (clk),
      .rst   (reset),
      .d_i   (pin_raw[gi]),
      .q_o   (sync_lvl[gi]),
      .rise_o(sync_rise[gi]),
      .fall_o(sync_fall[gi])
    );
  end

  logic cs_fall, cs_rise, sclk_rise, sclk_fall, saddr_lvl;
  logic unused_bits;

  assign cs_fall     = sync_fall[0];
  assign cs_rise     = sync_rise[0];
  assign sclk_rise   = sync_rise[1];
  assign sclk_fall   = sync_fall[1];
  assign saddr_lvl   = sync_lvl[2];
  assign unused_bits = ^{sync_lvl[1:0], sync_rise[2], sync_fall[2]};

  adc_state_e          state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d, load_word;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  adc_chan_t           addr_sh_q, addr_sh_d;
  adc_chan_t           next_chan_q, next_chan_d;
  adc_chan_t           last_chan_q, last_chan_d;
  logic                wrapped_q, wrapped_d;
  logic                frame_done_q, frame_done_d;
  logic [DATA_W-1:0]   chan_q [NUM_CH];
  logic                sdat;

  // Channel bank: a load on the same clk as a write sees the pre-write value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) chan_q[i] <= '0;
    end else if (wr_en) begin
      chan_q[wr_chan] <= wr_data;
    end
  end

  assign load_word = {{(FRAME_BITS-DATA_W){1'b0}}, chan_q[next_chan_q]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ADC_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ADC_IDLE:  if (cs_fall) state_d = ADC_SHIFT;
      ADC_SHIFT: if (cs_rise) state_d = ADC_IDLE;
      default:   state_d = ADC_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    sdat = 1'b0;
    if (state_q == ADC_SHIFT) begin
      busy = 1'b1;
      if (!cs_rise) sdat = shreg_q[FRAME_BITS-1];
    end
  end

  assign bus.ADC_SDAT = sdat;

  always_comb begin
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    addr_sh_d    = addr_sh_q;
    next_chan_d  = next_chan_q;
    last_chan_d  = last_chan_q;
    wrapped_d    = wrapped_q;
    frame_done_d = 1'b0;
    if (state_q == ADC_IDLE) begin
      if (cs_fall) begin
        shreg_d   = load_word;
        bit_cnt_d = '0;
        addr_sh_d = '0;
        wrapped_d = 1'b0;
      end
    end else if (!cs_rise) begin
      // A clock edge coinciding with the select release is deliberately dropped.
      if (sclk_rise) begin
        if (in_addr_window(int'(bit_cnt_q))) addr_sh_d = {addr_sh_q[1:0], saddr_lvl};
        if (bit_cnt_q == LAST_BIT) begin
          next_chan_d  = addr_sh_q;
          last_chan_d  = addr_sh_q;
          frame_done_d = 1'b1;
          bit_cnt_d    = '0;
          wrapped_d    = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end else if (sclk_fall) begin
        if (bit_cnt_q != '0) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
        end else if (wrapped_q) begin
          // Back-to-back frame under a held select: reload instead of shifting.
          shreg_d   = load_word;
          wrapped_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      addr_sh_q    <= '0;
      next_chan_q  <= '0;
      last_chan_q  <= '0;
      wrapped_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      addr_sh_q    <= addr_sh_d;
      next_chan_q  <= next_chan_d;
      last_chan_q  <= last_chan_d;
      wrapped_q    <= wrapped_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done = frame_done_q;
  assign last_chan  = last_chan_q;

endmodule

// File: tb/tb_adc_responder.sv
// Bench for adc_responder: a bit-banged master plus a channel-bank model and a
// scoreboard of expected 16-bit frames.
module tb_adc_responder;
  import adc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  adc_chan_t   wr_chan;
  logic [11:0] wr_data;
  logic        frame_done;
  adc_chan_t   last_chan;
  logic        busy;

  adc_if bus ();

  adc_responder dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .wr_en     (wr_en),
    .wr_chan   (wr_chan),
    .wr_data   (wr_data),
    .frame_done(frame_done),
    .last_chan (last_chan),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int fd_cnt      = 0;

  logic [11:0] model_chan [8];
  adc_chan_t   model_next;
  logic [15:0] exp_q [$];

  always @(posedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic wr(input adc_chan_t ch, input logic [11:0] v);
    wr_en = 1'b1; wr_chan = ch; wr_data = v;
    @(negedge clk);
    wr_en = 1'b0;
    model_chan[ch] = v;
  endtask

  // Bit-bang one frame (or part of one); data collects SDAT sampled at each pin-level rise.
  task automatic frame(input adc_chan_t addr, input int nbits, input bit do_fall,
                       input bit do_rise, input bit coinc, input bit wr_load,
                       input adc_chan_t wch, input logic [11:0] wdat,
                       output logic [15:0] data);
    data = '0;
    if (do_fall) begin
      bus.CS_N = 1'b0;
      repeat (2) @(negedge clk);
      if (wr_load) begin wr_en = 1'b1; wr_chan = wch; wr_data = wdat; end
      @(negedge clk);
      wr_en = 1'b0;
      repeat (3) @(negedge clk);
      check("busy_in_frame", busy, 1);
    end
    for (int k = 0; k < nbits; k++) begin
      bus.ADC_SCLK = 1'b0;
      repeat (3) @(negedge clk);
      bus.ADC_SADDR = (k >= 2 && k <= 4) ? addr[4-k] : 1'b0;
      repeat (3) @(negedge clk);
      data = {data[14:0], bus.ADC_SDAT};
      bus.ADC_SCLK = 1'b1;
      if (coinc && k == nbits - 1) bus.CS_N = 1'b1;
      repeat (6) @(negedge clk);
    end
    if (do_rise && !coinc) bus.CS_N = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic full(input adc_chan_t addr, input bit do_fall, input bit do_rise,
                      input bit wr_load, input logic [11:0] wdat);
    logic [15:0] got;
    int fd0;
    exp_q.push_back({4'b0, model_chan[model_next]});
    if (wr_load) model_chan[addr] = wdat;
    fd0 = fd_cnt;
    frame(addr, 16, do_fall, do_rise, 1'b0, wr_load, addr, wdat, got);
    check($sformatf("sdat_addr%0d", addr), got, exp_q.pop_front());
    model_next = addr;
    check("last_chan", last_chan, addr);
    check("frame_done_cnt", fd_cnt - fd0, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] dummy;
    int fd0;
    reset = 1'b1; wr_en = 1'b0; wr_chan = '0; wr_data = '0;
    bus.CS_N = 1'b1; bus.ADC_SCLK = 1'b1; bus.ADC_SADDR = 1'b0;
    for (int i = 0; i < 8; i++) model_chan[i] = '0;
    model_next = '0;
    repeat (3) @(negedge clk);
    check("rst_sdat", bus.ADC_SDAT, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_last_chan", last_chan, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Basic: channel 0 after reset, then the channel addressed in frame 1.
    wr(3'd5, 12'hABC);
    full(3'd5, 1, 1, 0, '0);
    full(3'd0, 1, 1, 0, '0);

    // Continuous mode: select held low across two frames.
    wr(3'd3, 12'h7FF);
    full(3'd3, 1, 0, 0, '0);
    full(3'd3, 0, 1, 0, '0);

    // Abort after 8 clocks: nothing committed.
    fd0 = fd_cnt;
    frame(3'd6, 8, 1, 1, 0, 0, '0, '0, dummy);
    check("abort_sdat", bus.ADC_SDAT, 0);
    check("abort_busy", busy, 0);
    check("abort_no_done", fd_cnt - fd0, 0);
    check("abort_last_chan", last_chan, 3);
    full(3'd2, 1, 1, 0, '0);

    // Write coinciding with the frame load.
    wr(3'd2, 12'h456);
    full(3'd2, 1, 1, 1, 12'h123);
    full(3'd2, 1, 1, 0, '0);

    // Select release on the same synchronized clk as the 16th rise.
    fd0 = fd_cnt;
    frame(3'd5, 16, 1, 1, 1, 0, '0, '0, dummy);
    check("coinc_no_done", fd_cnt - fd0, 0);
    check("coinc_last_chan", last_chan, 2);
    check("coinc_busy", busy, 0);
    full(3'd0, 1, 1, 0, '0);

    // Reset at bit 10 of a frame.
    wr(3'd7, 12'hFFF);
    frame(3'd7, 10, 1, 0, 0, 0, '0, '0, dummy);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_sdat", bus.ADC_SDAT, 0);
    check("midrst_last_chan", last_chan, 0);
    bus.CS_N = 1'b1; bus.ADC_SCLK = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) model_chan[i] = '0;
    model_next = '0;
    repeat (4) @(negedge clk);
    check("postrst_busy", busy, 0);
    full(3'd3, 1, 1, 0, '0);
    full(3'd7, 1, 1, 0, '0);
    full(3'd0, 1, 1, 0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_responder.md
Name: adc_responder

Overview:
Synthesizable slave-side model of the 8-channel, 12-bit serial ADC that the drum-pad acquisition front end polls over CS_N/ADC_SCLK/ADC_SADDR/ADC_SDAT. It samples the master's channel address and shifts out 12-bit channel values from a writable register bank. It is used in FPGA loopback builds and testbenches, so pad-acquisition logic can be exercised without the physical ADC. All protocol inputs are oversampled in the system clock domain.

Parameters:
DATA_W, 12, sample width per channel
FRAME_BITS, 16, SCLK periods per conversion frame (4 leading zeros + DATA_W)
NUM_CH, 8, number of channel registers (address width = 3)
SYNC_STAGES, 2, synchronizer depth on CS_N, ADC_SCLK and ADC_SADDR

Ports:
clk  in  1  system clock; must be at least 4x ADC_SCLK
reset  in  1  asynchronous, active-high reset
CS_N  in  1  frame select from master, active low
ADC_SCLK  in  1  serial clock from master
ADC_SADDR  in  1  serial channel address from master, sampled on SCLK rising edge
ADC_SDAT  out  1  serial data to master, MSB first, updated on SCLK falling edge
wr_en  in  1  channel register write strobe
wr_chan  in  3  channel index to write
wr_data  in  DATA_W  value to write
frame_done  out  1  one-clk pulse when a full frame completes
last_chan  out  3  address captured in the most recent completed frame
busy  out  1  high while a frame is in progress

Behaviour:
- Reset values: ADC_SDAT=0, frame_done=0, last_chan=0, busy=0. All channel registers reset to 0, and the next-conversion channel resets to 0. CS_N and SCLK synchronizers reset to 1, SADDR synchronizer to 0.
- Edge detection uses synchronized signals only: cs_fall, cs_rise, sclk_rise, sclk_fall. Each pulses for exactly one clk.
- FSM states: IDLE, SHIFT.
- IDLE: ADC_SDAT=0, busy=0. On cs_fall:
  - load shreg = {4'b0, chan_reg[next_chan]}
  - set bit_cnt=0, addr_sh=0
  - go to SHIFT
  ADC_SDAT is valid from the following clk.
- SHIFT: ADC_SDAT = shreg[FRAME_BITS-1], busy=1.
  - sclk_rise: if bit_cnt is 2, 3 or 4, shift ADC_SADDR into addr_sh (bit_cnt=2 is the address MSB). Then bit_cnt <= bit_cnt+1.
  - sclk_rise with bit_cnt==FRAME_BITS-1 (16th rising edge): next_chan <= addr_sh, last_chan <= addr_sh, frame_done pulses the next clk, and bit_cnt wraps to 0.
  - sclk_fall with bit_cnt!=0: shift shreg left by 1, filling with 0.
  - sclk_fall with bit_cnt==0 after a wrap (continuous mode, CS_N still low): reload shreg = {4'b0, chan_reg[next_chan]} instead of shifting. The new frame returns the channel addressed in the previous frame.
- cs_rise in SHIFT (abort or normal end): go to IDLE and set ADC_SDAT=0 that clk.
  - If 16 rising edges completed, next_chan is already updated.
  - Otherwise next_chan, last_chan and frame_done are unchanged.
- cs_rise and sclk_rise in the same clk: cs_rise wins and the edge is ignored.
- Channel writes: wr_en writes chan_reg[wr_chan] in any state. A frame uses the value snapshotted at load time. A write on the same clk as a load delivers the old value; the new value appears in the next frame.
- Latency: ADC_SDAT changes SYNC_STAGES+1 clk after the pin-level SCLK falling edge.
- reset mid-frame: immediate return to IDLE with all reset values.

Decomposition:
- Package adc_pkg: ADC_DATA_W, ADC_FRAME_BITS, ADC_NUM_CH, the adc_chan_t (logic [2:0]) typedef, and the responder state enum. The existing master should also import this package.
- One sub-module, sync_edge: a parameterised N-stage synchronizer with rise/fall pulse outputs and a reset value. It is instantiated three times.

Test Plan:
- Reset, write ch5=0xABC, run frame 1 with SADDR=101 then frame 2 with SADDR=000 -> frame 1 SDAT is 0x0000 (channel 0 after reset); frame 2 SDAT is 0x0ABC; last_chan=5 after frame 1.
- Continuous mode: CS_N held low for 32 SCLKs with addresses 3 then 3, ch3=0x7FF -> second 16 bits equal 0x07FF; frame_done pulses twice.
- Abort: CS_N rises after 8 SCLKs of a frame addressing ch6 -> no frame_done, last_chan unchanged, SDAT=0, next frame still uses the old next_chan.
- Write ch2=0x123 on the same clk as cs_fall for a ch2 frame (previous value 0x456) -> that frame shifts 0x0456, the next ch2 frame shifts 0x0123.
- Assert reset at bit 10 of a frame -> busy=0, SDAT=0, all channel registers read back 0 in the next frame.
- Edge coincidence: CS_N rises on the same synchronized clk as the 16th SCLK rise -> frame treated as incomplete, no frame_done.
